rv32i_exec_unit: RTL and testbench

- Combined RV32I decode/execute datapath: immediate decoder, integer ALU, branch comparator and next-PC/result selection.
- Consumes one fetched instruction plus its register operands and PC per valid beat.
- Produces registered writeback/address value, branch decision, next PC, write-enable and exception flags one clock later.
- Sits between the regfile/fetch logic and the writeback/memory stage of the single-cycle RV32I core.

---
 rtl/rv32i_exec_unit.sv | 200 ++++++++++++++++++++
 tb/tb_rv32i_exec_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_unit.sv
// RV32I decode/execute datapath: immediate decode, ALU, branch compare and next-PC/result select.
// All outputs are registered and update one clock after an accepted in_valid beat.
module rv32i_exec_unit #(
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic [31:0] store_data,
  output logic        br_taken,
  output logic [31:0] next_pc,
  output logic        rd_we,
  output logic        is_load,
  output logic        is_store,
  output logic        sys_halt,
  output logic        illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  // The reserved parameter is folded in with no functional effect.
  localparam logic [31:0] PcStep = 32'd4 + 32'(RESET_PC_UNUSED * 0);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_d;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        f7_alt;
  logic [31:0] alu_out;
  logic        br_cond;
  logic        illegal_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] rs1_plus_imm;
  logic [31:0] result_d;
  logic [31:0] next_pc_d;
  logic        rd_we_d;
  logic        br_taken_d;
  logic        writes_rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign f7_alt = (funct7 == F7Alt);

  always_comb begin
    imm_d = '0;
    unique case (opcode)
      OpLoad, OpImm, OpJalr, OpSystem: imm_d = {{20{instr[31]}}, instr[31:20]};
      OpStore:          imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OpBranch:         imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
      OpLui, OpAuipc:   imm_d = {instr[31:12], 12'b0};
      OpJal:            imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
      default:          imm_d = '0;
    endcase
  end

  assign op_b  = opcode[5] ? rs2_data : imm_d;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_out = '0;
    unique case (funct3)
      3'b000: alu_out = (opcode == OpReg && f7_alt) ? rs1_data - op_b : rs1_data + op_b;
      3'b001: alu_out = rs1_data << shamt;
      3'b010: alu_out = {31'b0, $signed(rs1_data) < $signed(op_b)};
      3'b011: alu_out = {31'b0, rs1_data < op_b};
      3'b100: alu_out = rs1_data ^ op_b;
      3'b101: alu_out = f7_alt ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
      3'b110: alu_out = rs1_data | op_b;
      3'b111: alu_out = rs1_data & op_b;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    unique case (funct3)
      3'b000: br_cond = (rs1_data == rs2_data);
      3'b001: br_cond = (rs1_data != rs2_data);
      3'b100: br_cond = ($signed(rs1_data) < $signed(rs2_data));
      3'b101: br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110: br_cond = (rs1_data < rs2_data);
      3'b111: br_cond = (rs1_data >= rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    illegal_d = 1'b0;
    unique case (opcode)
      OpLoad, OpAuipc, OpStore, OpLui, OpJalr, OpJal, OpSystem: illegal_d = 1'b0;
      OpReg: illegal_d = !(funct7 == 7'b0) &&
                         !(f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
      OpImm: illegal_d = (funct3 == 3'b001 && funct7 != 7'b0) ||
                         (funct3 == 3'b101 && funct7 != 7'b0 && !f7_alt);
      OpBranch: illegal_d = (funct3 == 3'b010 || funct3 == 3'b011);
      default: illegal_d = 1'b1;
    endcase
  end

  assign pc_plus4     = pc + PcStep;
  assign pc_plus_imm  = pc + imm_d;
  assign rs1_plus_imm = rs1_data + imm_d;
  assign br_taken_d   = (opcode == OpBranch) && !illegal_d && br_cond;

  always_comb begin
    result_d  = '0;
    next_pc_d = pc_plus4;
    writes_rd = 1'b0;
    unique case (opcode)
      OpReg, OpImm: begin
        result_d  = alu_out;
        writes_rd = 1'b1;
      end
      OpLui: begin
        result_d  = imm_d;
        writes_rd = 1'b1;
      end
      OpAuipc: begin
        result_d  = pc_plus_imm;
        writes_rd = 1'b1;
      end
      OpJal: begin
        result_d  = pc_plus4;
        next_pc_d = pc_plus_imm;
        writes_rd = 1'b1;
      end
      OpJalr: begin
        result_d  = pc_plus4;
        next_pc_d = rs1_plus_imm & ~32'd1;
        writes_rd = 1'b1;
      end
      OpLoad: begin
        result_d  = rs1_plus_imm;
        writes_rd = 1'b1;
      end
      OpStore: result_d = rs1_plus_imm;
      OpBranch: if (br_taken_d) next_pc_d = pc_plus_imm;
      default: result_d = '0;
    endcase
    if (illegal_d) next_pc_d = pc_plus4;
  end

  assign rd_we_d = writes_rd && (rd != 5'd0) && !illegal_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      imm        <= '0;
      result     <= '0;
      store_data <= '0;
      br_taken   <= 1'b0;
      next_pc    <= '0;
      rd_we      <= 1'b0;
      is_load    <= 1'b0;
      is_store   <= 1'b0;
      sys_halt   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm        <= imm_d;
        result     <= result_d;
        store_data <= rs2_data;
        br_taken   <= br_taken_d;
        next_pc    <= next_pc_d;
        rd_we      <= rd_we_d;
        is_load    <= (opcode == OpLoad) && !illegal_d;
        is_store   <= (opcode == OpStore) && !illegal_d;
        sys_halt   <= (opcode == OpSystem);
        illegal    <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Self-checking bench for rv32i_exec_unit: randomized instructions against an ISA-level
// model, plus literal expectations for the documented example instructions.
module tb_rv32i_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic [31:0] imm;
  logic [31:0] result;
  logic [31:0] store_data;
  logic        br_taken;
  logic [31:0] next_pc;
  logic        rd_we;
  logic        is_load;
  logic        is_store;
  logic        sys_halt;
  logic        illegal;

  rv32i_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .imm        (imm),
    .result     (result),
    .store_data (store_data),
    .br_taken   (br_taken),
    .next_pc    (next_pc),
    .rd_we      (rd_we),
    .is_load    (is_load),
    .is_store   (is_store),
    .sys_halt   (sys_halt),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] next_pc;
    logic        br_taken;
    logic        rd_we;
    logic        is_load;
    logic        is_store;
    logic        sys_halt;
    logic        illegal;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a, b,
                                      input logic alt_sub, input logic alt_sra);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0: return alt_sub ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt_sra ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] i, p, a, b);
    exp_t m;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       wr;
    logic       take;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    m = '0;
    wr = 1'b0;
    m.store_data = b;
    m.next_pc = p + 32'd4;
    case (op)
      7'h03: begin
        m.imm = {{20{i[31]}}, i[31:20]};
        m.result = a + m.imm;
        m.is_load = 1'b1;
        wr = 1'b1;
      end
      7'h13: begin
        m.imm = {{20{i[31]}}, i[31:20]};
        m.illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        m.result = alu(f3, a, m.imm, 1'b0, f7 == 7'h20);
        wr = 1'b1;
      end
      7'h33: begin
        m.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        m.result = alu(f3, a, b, f7 == 7'h20, f7 == 7'h20);
        wr = 1'b1;
      end
      7'h37: begin
        m.imm = {i[31:12], 12'h000};
        m.result = m.imm;
        wr = 1'b1;
      end
      7'h17: begin
        m.imm = {i[31:12], 12'h000};
        m.result = p + m.imm;
        wr = 1'b1;
      end
      7'h6f: begin
        m.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        m.result = p + 32'd4;
        m.next_pc = p + m.imm;
        wr = 1'b1;
      end
      7'h67: begin
        m.imm = {{20{i[31]}}, i[31:20]};
        m.result = p + 32'd4;
        m.next_pc = (a + m.imm) & 32'hFFFF_FFFE;
        wr = 1'b1;
      end
      7'h63: begin
        m.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = !($signed(a) < $signed(b));
          3'd6: take = (a < b);
          3'd7: take = !(a < b);
          default: begin
            take = 1'b0;
            m.illegal = 1'b1;
          end
        endcase
        m.br_taken = take;
        if (take) m.next_pc = p + m.imm;
      end
      7'h23: begin
        m.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        m.result = a + m.imm;
        m.is_store = 1'b1;
      end
      7'h73: begin
        m.imm = {{20{i[31]}}, i[31:20]};
        m.sys_halt = 1'b1;
      end
      default: m.illegal = 1'b1;
    endcase
    m.rd_we = wr && (i[11:7] != 5'd0);
    if (m.illegal) begin
      m.rd_we = 1'b0;
      m.is_load = 1'b0;
      m.is_store = 1'b0;
      m.br_taken = 1'b0;
      m.next_pc = p + 32'd4;
    end
    return m;
  endfunction

  exp_t exp_q;
  logic exp_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_v <= 1'b0;
      exp_q <= '0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) exp_q <= model(instr, pc, rs1_data, rs2_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t instr=0x%08h)",
               name, act, req, $time, instr);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      chk("imm", imm, exp_q.imm);
      chk("result", result, exp_q.result);
      chk("store_data", store_data, exp_q.store_data);
      chk("next_pc", next_pc, exp_q.next_pc);
      chk("br_taken", {31'b0, br_taken}, {31'b0, exp_q.br_taken});
      chk("rd_we", {31'b0, rd_we}, {31'b0, exp_q.rd_we});
      chk("is_load", {31'b0, is_load}, {31'b0, exp_q.is_load});
      chk("is_store", {31'b0, is_store}, {31'b0, exp_q.is_store});
      chk("sys_halt", {31'b0, sys_halt}, {31'b0, exp_q.sys_halt});
      chk("illegal", {31'b0, illegal}, {31'b0, exp_q.illegal});
    end
  end

  task automatic step(input logic v, input logic [31:0] i, p, a, b);
    in_valid = v;
    instr    = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opcs [10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                            7'h63, 7'h67, 7'h6f, 7'h73};

  initial begin
    logic [31:0] ri, ra, rb, rp;
    rst_n = 1'b0;
    in_valid = 1'b0;
    instr = '0;
    pc = '0;
    rs1_data = '0;
    rs2_data = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_next_pc", next_pc, 32'd0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    step(1'b1, 32'h0020_8133, 32'h40, 32'd5, 32'd7);
    chk("add_result", result, 32'd12);
    chk("add_rd_we", {31'b0, rd_we}, 32'd1);
    chk("add_next_pc", next_pc, 32'h44);
    chk("add_illegal", {31'b0, illegal}, 32'd0);
    step(1'b1, 32'h4020_8133, 32'h40, 32'd5, 32'd7);
    chk("sub_result", result, 32'hFFFF_FFFE);
    step(1'b1, 32'h4040_D093, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_result", result, 32'hF800_0000);
    chk("srai_shamt", {27'b0, imm[4:0]}, 32'd4);
    step(1'b1, 32'h1234_5037, 32'h0, 32'h0, 32'h0);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_result", result, 32'h1234_5000);
    step(1'b1, 32'hFE20_8CE3, 32'h100, 32'd3, 32'd3);
    chk("beq_imm", imm, 32'hFFFF_FFF8);
    chk("beq_taken", {31'b0, br_taken}, 32'd1);
    chk("beq_next_pc", next_pc, 32'hF8);
    chk("beq_rd_we", {31'b0, rd_we}, 32'd0);
    step(1'b1, 32'hFE20_8CE3, 32'h100, 32'd3, 32'd4);
    chk("bne_taken", {31'b0, br_taken}, 32'd0);
    chk("bne_next_pc", next_pc, 32'h104);
    step(1'b1, 32'h0032_80E7, 32'h200, 32'h1000, 32'h0);
    chk("jalr_next_pc", next_pc, 32'h1002);
    chk("jalr_result", result, 32'h204);
    chk("jalr_rd_we", {31'b0, rd_we}, 32'd1);
    step(1'b1, 32'h0000_000B, 32'h300, 32'h0, 32'h0);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_rd_we", {31'b0, rd_we}, 32'd0);
    chk("ill_next_pc", next_pc, 32'h304);
    step(1'b1, 32'h0000_0073, 32'h400, 32'h0, 32'h0);
    chk("ecall_halt", {31'b0, sys_halt}, 32'd1);
    chk("ecall_rd_we", {31'b0, rd_we}, 32'd0);
    step(1'b0, 32'h0020_8133, 32'h40, 32'd5, 32'd7);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_hold_next_pc", next_pc, 32'h404);
    chk("idle_hold_halt", {31'b0, sys_halt}, 32'd1);
    step(1'b1, 32'h0020_8133, 32'h40, 32'd5, 32'd7);
    rst_n = 1'b0;
    step(1'b1, 32'h0020_8133, 32'h40, 32'd5, 32'd7);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_we", {31'b0, rd_we}, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      ri = $urandom;
      if ($urandom_range(15) != 0) ri[6:0] = opcs[$urandom_range(9)];
      if ((ri[6:0] == 7'h33 || ri[6:0] == 7'h13) && $urandom_range(3) != 0)
        ri[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: rb = ra;
        1: begin
          ra = $urandom_range(1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          rb = $urandom_range(1) ? 32'hFFFF_FFFF : 32'h0;
        end
        default: ;
      endcase
      rp = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rst_n = ($urandom_range(63) != 0);
      step($urandom_range(4) != 0, ri, rp, ra, rb);
    end
    rst_n = 1'b1;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
